// File: rtl/axi_lite_if.sv
// Shared types for the AXI4-Lite crossbar: target select,
// response codes, FSM states and the window-hit helper.
package axi_lite_if;

  typedef enum logic [1:0] {
    SEL_SRAM = 2'd0,
    SEL_UART = 2'd1,
    SEL_NONE = 2'd2
  } sel_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    R_IDLE,
    R_ADDR,
    R_DATA,
    R_ERR
  } rd_state_t;

  typedef enum logic [2:0] {
    W_IDLE,
    W_AW_WAIT,
    W_W_WAIT,
    W_FWD,
    W_RESP,
    W_ERR
  } wr_state_t;

  // Subtract first so a window touching 2^32 cannot wrap.
  function automatic logic addr_hit(
    input logic [31:0] addr,
    input logic [31:0] base,
    input logic [31:0] size
  );
    logic [31:0] off;
    off = addr - base;
    return (addr >= base) && (off < size);
  endfunction

endpackage

// File: rtl/axi_if.sv
// AXI4-Lite bundle with master/slave views.
interface axi_if;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport master (
    output awaddr, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arvalid, input arready,
    input rdata, rresp, rvalid, output rready
  );

  modport slave (
    input awaddr, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/axi_lite_addr_decode.sv
// Combinational address-to-target decode for the fixed
// SRAM/UART memory map.
module axi_lite_addr_decode
  import axi_lite_if::*;
#(
  parameter logic [31:0] SRAM_BASE = 32'h8000_0000,
  parameter logic [31:0] SRAM_SIZE = 32'h0800_0000,
  parameter logic [31:0] UART_BASE = 32'ha000_03f8,
  parameter logic [31:0] UART_SIZE = 32'h0000_0008
) (
  input  logic [31:0] addr,
  output sel_t        sel
);

  always_comb begin
    sel = SEL_NONE;
    unique case (1'b1)
      addr_hit(addr, SRAM_BASE, SRAM_SIZE):
        sel = SEL_SRAM;
      addr_hit(addr, UART_BASE, UART_SIZE):
        sel = SEL_UART;
      default:
        sel = SEL_NONE;
    endcase
  end

endmodule

// File: rtl/axi_lite_xbar.sv
// 1-to-2 AXI4-Lite router: LSU master to SRAM or UART,
// unmapped accesses answered locally with DECERR.
module axi_lite_xbar
  import axi_lite_if::*;
#(
  parameter logic [31:0] SRAM_BASE = 32'h8000_0000,
  parameter logic [31:0] SRAM_SIZE = 32'h0800_0000,
  parameter logic [31:0] UART_BASE = 32'ha000_03f8,
  parameter logic [31:0] UART_SIZE = 32'h0000_0008
) (
  input logic   clk,
  input logic   reset,
  axi_if.slave  up,
  axi_if.master sram,
  axi_if.master uart
);

  sel_t ar_sel;
  sel_t aw_sel;

  axi_lite_addr_decode #(
    .SRAM_BASE(SRAM_BASE), .SRAM_SIZE(SRAM_SIZE),
    .UART_BASE(UART_BASE), .UART_SIZE(UART_SIZE)
  ) u_ar_dec (
    .addr(up.araddr),
    .sel (ar_sel)
  );

  axi_lite_addr_decode #(
    .SRAM_BASE(SRAM_BASE), .SRAM_SIZE(SRAM_SIZE),
    .UART_BASE(UART_BASE), .UART_SIZE(UART_SIZE)
  ) u_aw_dec (
    .addr(up.awaddr),
    .sel (aw_sel)
  );

  rd_state_t   rd_state_q, rd_state_d;
  logic [31:0] ar_addr_q, ar_addr_d;
  sel_t        ar_sel_q, ar_sel_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_state_q <= R_IDLE;
      ar_addr_q  <= '0;
      ar_sel_q   <= SEL_SRAM;
    end else begin
      rd_state_q <= rd_state_d;
      ar_addr_q  <= ar_addr_d;
      ar_sel_q   <= ar_sel_d;
    end
  end

  logic r_sram;
  logic r_uart;
  logic r_vld;

  always_comb begin
    rd_state_d   = rd_state_q;
    ar_addr_d    = ar_addr_q;
    ar_sel_d     = ar_sel_q;
    r_sram       = (ar_sel_q == SEL_SRAM);
    r_uart       = (ar_sel_q == SEL_UART);
    r_vld        = 1'b0;
    up.arready   = 1'b0;
    up.rvalid    = 1'b0;
    up.rdata     = '0;
    up.rresp     = RESP_OKAY;
    sram.arvalid = 1'b0;
    sram.araddr  = ar_addr_q;
    sram.rready  = 1'b0;
    uart.arvalid = 1'b0;
    uart.araddr  = ar_addr_q;
    uart.rready  = 1'b0;
    unique case (rd_state_q)
      R_IDLE: begin
        up.arready = 1'b1;
        if (up.arvalid) begin
          ar_addr_d  = up.araddr;
          ar_sel_d   = ar_sel;
          rd_state_d = (ar_sel == SEL_NONE)
                     ? R_ERR : R_ADDR;
        end
      end
      R_ADDR: begin
        sram.arvalid = r_sram;
        uart.arvalid = r_uart;
        if ((r_sram && sram.arready) ||
            (r_uart && uart.arready))
          rd_state_d = R_DATA;
      end
      R_DATA: begin
        r_vld       = r_sram ? sram.rvalid : uart.rvalid;
        up.rvalid   = r_vld;
        up.rdata    = r_sram ? sram.rdata : uart.rdata;
        up.rresp    = r_sram ? sram.rresp : uart.rresp;
        sram.rready = r_sram && up.rready;
        uart.rready = r_uart && up.rready;
        if (r_vld && up.rready)
          rd_state_d = R_IDLE;
      end
      R_ERR: begin
        up.rvalid = 1'b1;
        up.rresp  = RESP_DECERR;
        if (up.rready)
          rd_state_d = R_IDLE;
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  wr_state_t   wr_state_q, wr_state_d;
  logic [31:0] aw_addr_q, aw_addr_d;
  sel_t        aw_sel_q, aw_sel_d;
  logic [31:0] w_data_q, w_data_d;
  logic [3:0]  w_strb_q, w_strb_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_state_q <= W_IDLE;
      aw_addr_q  <= '0;
      aw_sel_q   <= SEL_SRAM;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
    end else begin
      wr_state_q <= wr_state_d;
      aw_addr_q  <= aw_addr_d;
      aw_sel_q   <= aw_sel_d;
      w_data_q   <= w_data_d;
      w_strb_q   <= w_strb_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
    end
  end

  logic       w_sram;
  logic       w_uart;
  logic       ds_awready;
  logic       ds_wready;
  logic       ds_bvalid;
  logic [1:0] ds_bresp;

  always_comb begin
    wr_state_d   = wr_state_q;
    aw_addr_d    = aw_addr_q;
    aw_sel_d     = aw_sel_q;
    w_data_d     = w_data_q;
    w_strb_d     = w_strb_q;
    aw_done_d    = aw_done_q;
    w_done_d     = w_done_q;
    w_sram       = (aw_sel_q == SEL_SRAM);
    w_uart       = (aw_sel_q == SEL_UART);
    ds_awready   = w_sram ? sram.awready : uart.awready;
    ds_wready    = w_sram ? sram.wready : uart.wready;
    ds_bvalid    = w_sram ? sram.bvalid : uart.bvalid;
    ds_bresp     = w_sram ? sram.bresp : uart.bresp;
    up.awready   = 1'b0;
    up.wready    = 1'b0;
    up.bvalid    = 1'b0;
    up.bresp     = RESP_OKAY;
    sram.awvalid = 1'b0;
    sram.awaddr  = aw_addr_q;
    sram.wvalid  = 1'b0;
    sram.wdata   = w_data_q;
    sram.wstrb   = w_strb_q;
    sram.bready  = 1'b0;
    uart.awvalid = 1'b0;
    uart.awaddr  = aw_addr_q;
    uart.wvalid  = 1'b0;
    uart.wdata   = w_data_q;
    uart.wstrb   = w_strb_q;
    uart.bready  = 1'b0;
    unique case (wr_state_q)
      W_IDLE: begin
        up.awready = 1'b1;
        up.wready  = 1'b1;
        if (up.awvalid) begin
          aw_addr_d = up.awaddr;
          aw_sel_d  = aw_sel;
        end
        if (up.wvalid) begin
          w_data_d = up.wdata;
          w_strb_d = up.wstrb;
        end
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
        if (up.awvalid && up.wvalid)
          wr_state_d = (aw_sel == SEL_NONE)
                     ? W_ERR : W_FWD;
        else if (up.awvalid)
          wr_state_d = W_W_WAIT;
        else if (up.wvalid)
          wr_state_d = W_AW_WAIT;
      end
      W_AW_WAIT: begin
        up.awready = 1'b1;
        if (up.awvalid) begin
          aw_addr_d  = up.awaddr;
          aw_sel_d   = aw_sel;
          aw_done_d  = 1'b0;
          w_done_d   = 1'b0;
          wr_state_d = (aw_sel == SEL_NONE)
                     ? W_ERR : W_FWD;
        end
      end
      W_W_WAIT: begin
        up.wready = 1'b1;
        if (up.wvalid) begin
          w_data_d   = up.wdata;
          w_strb_d   = up.wstrb;
          aw_done_d  = 1'b0;
          w_done_d   = 1'b0;
          wr_state_d = (aw_sel_q == SEL_NONE)
                     ? W_ERR : W_FWD;
        end
      end
      W_FWD: begin
        sram.awvalid = w_sram && !aw_done_q;
        uart.awvalid = w_uart && !aw_done_q;
        sram.wvalid  = w_sram && !w_done_q;
        uart.wvalid  = w_uart && !w_done_q;
        aw_done_d    = aw_done_q || ds_awready;
        w_done_d     = w_done_q || ds_wready;
        if (aw_done_d && w_done_d)
          wr_state_d = W_RESP;
      end
      W_RESP: begin
        up.bvalid   = ds_bvalid;
        up.bresp    = ds_bresp;
        sram.bready = w_sram && up.bready;
        uart.bready = w_uart && up.bready;
        if (ds_bvalid && up.bready)
          wr_state_d = W_IDLE;
      end
      W_ERR: begin
        up.bvalid = 1'b1;
        up.bresp  = RESP_DECERR;
        if (up.bready)
          wr_state_d = W_IDLE;
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi_lite_xbar.sv
// Directed bench for axi_lite_xbar: the bench plays the
// LSU master and both slaves cycle by cycle.
module tb_axi_lite_xbar;

  logic clk;
  logic reset;

  axi_if up_if ();
  axi_if sram_if ();
  axi_if uart_if ();

  axi_lite_xbar dut (
    .clk  (clk),
    .reset(reset),
    .up   (up_if),
    .sram (sram_if),
    .uart (uart_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  int uart_ar_cnt = 0;
  int sram_w_cnt  = 0;
  int bhs_cnt     = 0;

  always @(posedge clk) begin
    if (uart_if.arvalid)
      uart_ar_cnt <= uart_ar_cnt + 1;
    if (sram_if.awvalid || sram_if.wvalid)
      sram_w_cnt <= sram_w_cnt + 1;
    if (up_if.bvalid && up_if.bready)
      bhs_cnt <= bhs_cnt + 1;
  end

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] want
  );
    n_tests++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, want);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  logic [31:0] baddr [7];
  logic [2:0]  bexp  [7];

  initial begin
    reset           = 1'b0;
    up_if.awaddr    = '0;
    up_if.awvalid   = 1'b0;
    up_if.wdata     = '0;
    up_if.wstrb     = '0;
    up_if.wvalid    = 1'b0;
    up_if.bready    = 1'b0;
    up_if.araddr    = '0;
    up_if.arvalid   = 1'b0;
    up_if.rready    = 1'b0;
    sram_if.awready = 1'b0;
    sram_if.wready  = 1'b0;
    sram_if.bresp   = 2'b00;
    sram_if.bvalid  = 1'b0;
    sram_if.arready = 1'b0;
    sram_if.rdata   = '0;
    sram_if.rresp   = 2'b00;
    sram_if.rvalid  = 1'b0;
    uart_if.awready = 1'b0;
    uart_if.wready  = 1'b0;
    uart_if.bresp   = 2'b00;
    uart_if.bvalid  = 1'b0;
    uart_if.arready = 1'b0;
    uart_if.rdata   = '0;
    uart_if.rresp   = 2'b00;
    uart_if.rvalid  = 1'b0;

    baddr[0] = 32'h7fff_fffc; bexp[0] = 3'b001;
    baddr[1] = 32'h8000_0000; bexp[1] = 3'b100;
    baddr[2] = 32'h87ff_fffc; bexp[2] = 3'b100;
    baddr[3] = 32'h8800_0000; bexp[3] = 3'b001;
    baddr[4] = 32'ha000_03f7; bexp[4] = 3'b001;
    baddr[5] = 32'ha000_03ff; bexp[5] = 3'b010;
    baddr[6] = 32'ha000_0400; bexp[6] = 3'b001;

    // reset state
    cyc();
    chk("rst_ready",
        32'({up_if.arready, up_if.awready, up_if.wready}),
        32'h7);
    chk("rst_valids",
        32'({up_if.rvalid, up_if.bvalid,
             sram_if.arvalid, sram_if.awvalid,
             sram_if.wvalid, uart_if.arvalid,
             uart_if.awvalid, uart_if.wvalid}),
        32'h0);
    chk("rst_addr", sram_if.araddr, 32'h0);
    reset = 1'b1;
    cyc();

    // SRAM read, arready after 2 cycles
    up_if.arvalid = 1'b1;
    up_if.araddr  = 32'h8000_0010;
    up_if.rready  = 1'b1;
    cyc();
    up_if.arvalid = 1'b0;
    #1;
    chk("rd_arv_n1", 32'(sram_if.arvalid), 32'h1);
    chk("rd_araddr", sram_if.araddr, 32'h8000_0010);
    chk("rd_busy", 32'(up_if.arready), 32'h0);
    cyc();
    chk("rd_arv_hold", 32'(sram_if.arvalid), 32'h1);
    cyc();
    sram_if.arready = 1'b1;
    cyc();
    sram_if.arready = 1'b0;
    sram_if.rvalid  = 1'b1;
    sram_if.rdata   = 32'hdead_beef;
    #1;
    chk("rd_arv_drop", 32'(sram_if.arvalid), 32'h0);
    chk("rd_rvalid", 32'(up_if.rvalid), 32'h1);
    chk("rd_rdata", up_if.rdata, 32'hdead_beef);
    chk("rd_rresp", 32'(up_if.rresp), 32'h0);
    chk("rd_rready", 32'(sram_if.rready), 32'h1);
    cyc();
    sram_if.rvalid = 1'b0;
    #1;
    chk("rd_done", 32'(up_if.rvalid), 32'h0);
    chk("rd_idle", 32'(up_if.arready), 32'h1);
    chk("rd_uart_quiet", uart_ar_cnt, 0);

    // UART write, AW and W together
    up_if.awvalid = 1'b1;
    up_if.awaddr  = 32'ha000_03f8;
    up_if.wvalid  = 1'b1;
    up_if.wdata   = 32'h0000_0041;
    up_if.wstrb   = 4'h1;
    up_if.bready  = 1'b1;
    #1;
    chk("wr_idle_rdy",
        32'({up_if.awready, up_if.wready}), 32'h3);
    cyc();
    up_if.awvalid = 1'b0;
    up_if.wvalid  = 1'b0;
    #1;
    chk("wr_uart_v",
        32'({uart_if.awvalid, uart_if.wvalid}), 32'h3);
    chk("wr_awaddr", uart_if.awaddr, 32'ha000_03f8);
    chk("wr_wdata", 32'(uart_if.wdata[7:0]), 32'h41);
    uart_if.awready = 1'b1;
    uart_if.wready  = 1'b1;
    cyc();
    uart_if.awready = 1'b0;
    uart_if.wready  = 1'b0;
    uart_if.bvalid  = 1'b1;
    #1;
    chk("wr_fwd_drop",
        32'({uart_if.awvalid, uart_if.wvalid}), 32'h0);
    chk("wr_bvalid", 32'(up_if.bvalid), 32'h1);
    chk("wr_bresp", 32'(up_if.bresp), 32'h0);
    chk("wr_bready", 32'(uart_if.bready), 32'h1);
    cyc();
    uart_if.bvalid = 1'b0;
    #1;
    chk("wr_done", 32'(up_if.bvalid), 32'h0);

    // W before AW, uart.wready low 3 cycles
    up_if.wvalid = 1'b1;
    up_if.wdata  = 32'h0000_0042;
    cyc();
    up_if.wvalid  = 1'b0;
    up_if.awvalid = 1'b1;
    up_if.awaddr  = 32'ha000_03f8;
    #1;
    chk("wa_wait_rdy",
        32'({up_if.awready, up_if.wready}), 32'h2);
    cyc();
    up_if.awvalid   = 1'b0;
    uart_if.awready = 1'b1;
    #1;
    chk("wa_fwd_v",
        32'({uart_if.awvalid, uart_if.wvalid}), 32'h3);
    chk("wa_wdata", 32'(uart_if.wdata[7:0]), 32'h42);
    cyc();
    uart_if.awready = 1'b0;
    #1;
    chk("wa_aw_drop1",
        32'({uart_if.awvalid, uart_if.wvalid}), 32'h1);
    cyc();
    chk("wa_aw_drop2",
        32'({uart_if.awvalid, uart_if.wvalid}), 32'h1);
    uart_if.wready = 1'b1;
    cyc();
    uart_if.wready = 1'b0;
    uart_if.bvalid = 1'b1;
    #1;
    chk("wa_wv_drop", 32'(uart_if.wvalid), 32'h0);
    chk("wa_bvalid", 32'(up_if.bvalid), 32'h1);
    chk("wa_bresp", 32'(up_if.bresp), 32'h0);
    cyc();
    uart_if.bvalid = 1'b0;
    #1;
    chk("wa_bcount", bhs_cnt, 2);
    chk("wa_sram_quiet", sram_w_cnt, 0);

    // unmapped read and write
    up_if.arvalid = 1'b1;
    up_if.araddr  = 32'h1000_0000;
    up_if.rready  = 1'b0;
    cyc();
    up_if.arvalid = 1'b0;
    #1;
    chk("de_rvalid", 32'(up_if.rvalid), 32'h1);
    chk("de_rdata", up_if.rdata, 32'h0);
    chk("de_rresp", 32'(up_if.rresp), 32'h3);
    chk("de_ds_arv",
        32'({sram_if.arvalid, uart_if.arvalid}), 32'h0);
    up_if.rready = 1'b1;
    cyc();
    chk("de_rdone", 32'(up_if.rvalid), 32'h0);
    up_if.awvalid = 1'b1;
    up_if.awaddr  = 32'h1000_0000;
    up_if.wvalid  = 1'b1;
    up_if.bready  = 1'b0;
    cyc();
    up_if.awvalid = 1'b0;
    up_if.wvalid  = 1'b0;
    #1;
    chk("de_bvalid", 32'(up_if.bvalid), 32'h1);
    chk("de_bresp", 32'(up_if.bresp), 32'h3);
    chk("de_ds_awv",
        32'({sram_if.awvalid, sram_if.wvalid,
             uart_if.awvalid, uart_if.wvalid}), 32'h0);
    up_if.bready = 1'b1;
    cyc();
    chk("de_bdone", 32'(up_if.bvalid), 32'h0);

    // window edges: {sram arvalid, uart arvalid, rvalid}
    for (int i = 0; i < 7; i++) begin
      up_if.arvalid = 1'b1;
      up_if.araddr  = baddr[i];
      up_if.rready  = 1'b0;
      cyc();
      up_if.arvalid = 1'b0;
      #1;
      chk($sformatf("edge_%h", baddr[i]),
          32'({sram_if.arvalid, uart_if.arvalid,
               up_if.rvalid}),
          32'(bexp[i]));
      sram_if.arready = 1'b1;
      uart_if.arready = 1'b1;
      up_if.rready    = 1'b1;
      cyc();
      sram_if.arready = 1'b0;
      uart_if.arready = 1'b0;
      sram_if.rvalid  = 1'b1;
      uart_if.rvalid  = 1'b1;
      cyc();
      sram_if.rvalid = 1'b0;
      uart_if.rvalid = 1'b0;
    end
    chk("edge_idle", 32'(up_if.arready), 32'h1);

    // concurrent SRAM read and UART write
    up_if.arvalid = 1'b1;
    up_if.araddr  = 32'h8000_0100;
    up_if.rready  = 1'b0;
    up_if.awvalid = 1'b1;
    up_if.awaddr  = 32'ha000_03fc;
    up_if.wvalid  = 1'b1;
    up_if.wdata   = 32'h0000_0055;
    up_if.bready  = 1'b1;
    cyc();
    up_if.arvalid   = 1'b0;
    up_if.awvalid   = 1'b0;
    up_if.wvalid    = 1'b0;
    sram_if.arready = 1'b1;
    uart_if.awready = 1'b1;
    uart_if.wready  = 1'b1;
    #1;
    chk("cc_fwd",
        32'({sram_if.arvalid, uart_if.awvalid,
             uart_if.wvalid}), 32'h7);
    cyc();
    sram_if.arready = 1'b0;
    uart_if.awready = 1'b0;
    uart_if.wready  = 1'b0;
    sram_if.rvalid  = 1'b1;
    sram_if.rdata   = 32'h1234_5678;
    uart_if.bvalid  = 1'b1;
    #1;
    chk("cc_bvalid", 32'(up_if.bvalid), 32'h1);
    chk("cc_bresp", 32'(up_if.bresp), 32'h0);
    chk("cc_rhold0",
        32'({up_if.rvalid, sram_if.rready}), 32'h2);
    for (int i = 1; i < 4; i++) begin
      cyc();
      uart_if.bvalid = 1'b0;
      #1;
      chk($sformatf("cc_rhold%0d", i),
          32'({up_if.rvalid, sram_if.rready,
               up_if.bvalid}), 32'h4);
    end
    up_if.rready = 1'b1;
    #1;
    chk("cc_rready", 32'(sram_if.rready), 32'h1);
    chk("cc_rdata", up_if.rdata, 32'h1234_5678);
    chk("cc_rresp", 32'(up_if.rresp), 32'h0);
    cyc();
    sram_if.rvalid = 1'b0;
    #1;
    chk("cc_rdone", 32'(up_if.rvalid), 32'h0);

    // reset in R_ADDR / W_FWD
    up_if.arvalid = 1'b1;
    up_if.araddr  = 32'h8000_0000;
    up_if.awvalid = 1'b1;
    up_if.awaddr  = 32'h8000_0004;
    up_if.wvalid  = 1'b1;
    cyc();
    up_if.arvalid = 1'b0;
    up_if.awvalid = 1'b0;
    up_if.wvalid  = 1'b0;
    #1;
    chk("ab_pre",
        32'({sram_if.arvalid, sram_if.awvalid,
             sram_if.wvalid}), 32'h7);
    reset = 1'b0;
    #1;
    chk("ab_async",
        32'({sram_if.arvalid, sram_if.awvalid,
             sram_if.wvalid, up_if.rvalid,
             up_if.bvalid}), 32'h0);
    chk("ab_araddr_clr", sram_if.araddr, 32'h0);
    cyc();
    reset = 1'b1;
    cyc();
    chk("ab_idle",
        32'({up_if.arready, up_if.awready,
             up_if.wready, sram_if.arvalid}), 32'he);
    up_if.arvalid = 1'b1;
    up_if.araddr  = 32'h8000_0020;
    up_if.rready  = 1'b1;
    cyc();
    up_if.arvalid   = 1'b0;
    sram_if.arready = 1'b1;
    #1;
    chk("ab_next_ar", sram_if.araddr, 32'h8000_0020);
    cyc();
    sram_if.arready = 1'b0;
    sram_if.rvalid  = 1'b1;
    sram_if.rdata   = 32'hcafe_f00d;
    #1;
    chk("ab_next_rd", up_if.rdata, 32'hcafe_f00d);
    cyc();
    sram_if.rvalid = 1'b0;
    #1;
    chk("ab_next_done", 32'(up_if.rvalid), 32'h0);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_lite_xbar.md
Name: axi_lite_xbar

Overview:
- 1-to-2 AXI4-Lite address router between the core's LSU master port and the memory-mapped slaves.
- Decodes each read and write address against a fixed map and forwards the transaction to the SRAM slave or the UART slave.
- Unmapped addresses are answered locally with a decode-error response.
- Read and write paths are independent and may be in flight at the same time; each path carries at most one outstanding transaction.

Parameters:
- SRAM_BASE, 32'h8000_0000, SRAM window base.
- SRAM_SIZE, 32'h0800_0000, SRAM window size in bytes.
- UART_BASE, 32'ha000_03f8, UART window base.
- UART_SIZE, 32'h0000_0008, UART window size in bytes.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- up  axi_if.slave  -  upstream port, connected to the core master.
- sram  axi_if.master  -  downstream port to the SRAM slave.
- uart  axi_if.master  -  downstream port to the UART slave.

Behaviour:
- Address decode:
  - hit = (addr >= BASE) && (addr - BASE < SIZE), computed as a 32-bit unsigned compare.
  - Targets are SEL_SRAM, SEL_UART, or SEL_NONE when nothing hits.
  - The decode result is latched at the address handshake and held until the response completes.
- Reset (reset=0, asynchronous): both FSMs go to IDLE; all valids (sram/uart ar/aw/w valid, up.rvalid, up.bvalid) are 0; latched addr/data/sel registers are cleared to 0.
  - up.arready, up.awready and up.wready are derived from state and are 1 in IDLE.
  - Reset mid-transaction aborts it; no response is issued.
- Read FSM (states R_IDLE, R_ADDR, R_DATA, R_ERR):
  - R_IDLE: up.arready=1. On arvalid&arready, latch araddr and sel, then go to R_ERR if sel=SEL_NONE, else R_ADDR.
  - R_ADDR: drive selected arvalid=1 with the latched araddr. The non-selected port stays idle. On its arready, go to R_DATA.
  - R_DATA: combinationally pass the selected rvalid/rdata/rresp to up and up.rready to the selected rready. On up.rvalid&up.rready, go to R_IDLE.
  - R_ERR: up.rvalid=1, rdata=0, rresp=RESP_DECERR. On up.rready, go to R_IDLE.
  - Latency: AR accepted at cycle N gives downstream arvalid at N+1.
- Write FSM (states W_IDLE, W_AW_WAIT, W_W_WAIT, W_FWD, W_RESP, W_ERR):
  - W_IDLE: awready=wready=1. AW and W may arrive in either order or in the same cycle.
    - AW only: latch awaddr and sel, go to W_W_WAIT.
    - W only: latch wdata/wstrb, go to W_AW_WAIT.
    - Both: latch both, go to W_FWD (or W_ERR when SEL_NONE).
  - W_AW_WAIT: awready=1, wready=0. W_W_WAIT: wready=1, awready=0. Completing the missing half goes to W_FWD, or to W_ERR when sel=SEL_NONE.
  - W_FWD: selected awvalid and wvalid start at 1.
    - Each is dropped independently after its own handshake; per-channel done flags are cleared on entry.
    - When both are done, go to W_RESP.
    - Both handshakes in the same cycle is legal.
  - W_RESP: combinationally pass the selected bvalid/bresp to up and up.bready back. On up.bvalid&bready, go to W_IDLE.
  - W_ERR: up.bvalid=1, bresp=RESP_DECERR, and the write is dropped. On bready, go to W_IDLE.
- Downstream valids stay asserted until their handshake; the address and data presented remain stable while valid is high.
- A read and a write to the same slave may overlap; ordering between read and write is not guaranteed.

Decomposition:
- Package axi_lite_if gains:
  - typedef enum sel_t {SEL_SRAM, SEL_UART, SEL_NONE};
  - constants RESP_OKAY and RESP_DECERR;
  - rd_state_t and wr_state_t for this block.
- One sub-module, axi_lite_addr_decode: combinational address to sel_t, parameterised by the map. It is instantiated twice, once for AR and once for AW.

Test Plan:
- Read 0x8000_0010, SRAM returns rdata=0xDEAD_BEEF after 2-cycle arready delay -> up.rdata=0xDEAD_BEEF, rresp=OKAY, uart.arvalid never asserted.
- AW=0xa000_03f8 and W=0x41 in the same cycle -> uart aw/w valid at N+1, uart sees wdata[7:0]=0x41, up.bresp=OKAY, sram untouched.
- W (0x42) one cycle before AW 0xa000_03f8, with uart.wready held low 3 cycles -> awvalid drops after its handshake, wvalid holds until accepted, single bresp OKAY.
- Read 0x1000_0000 -> up.rvalid within 2 cycles, rdata=0, rresp=DECERR, no downstream valid. Write 0x1000_0000 -> bresp=DECERR.
- Concurrent SRAM read and UART write -> both complete with OKAY; up.rready held low 4 cycles holds sram.rready low and R_DATA.
- Assert reset in R_ADDR and W_FWD -> all valids 0 immediately (asynchronous), both FSMs IDLE after release, next transaction completes normally.
